// File: rtl/ram_pkg.sv
// Shared definitions for the RAM fill/check sequencer: sizes, FSM states and
// the fill pattern used both when writing and when checking the RAM.
package ram_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_SETUP  = 3'd1,
      WR_STROBE = 3'd2,
      GAP       = 3'd3,
      RD_SETUP  = 3'd4,
      RD_SAMPLE = 3'd5,
      DONE      = 3'd6
   } fc_state_t;

   // Pattern word for one address: seed plus zero-extended address, wrapping.
   function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] seed,
                                             input logic [ADDR_W-1:0] adrs);
      return seed + {{(DATA_W-ADDR_W){1'b0}}, adrs};
   endfunction

endpackage

// File: rtl/ram_strobe_gen.sv
// Registered decode of the sequencer state into the active-low RAM strobes and
// the write-data bus enable; fed with the next state so outputs align with it.
module ram_strobe_gen
   import ram_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  fc_state_t state_nxt,
   output logic      ram_ce_n,
   output logic      ram_we_n,
   output logic      ram_oe_n,
   output logic      data_oe
);

   logic ce_n_s;
   logic we_n_s;
   logic oe_n_s;
   logic doe_s;

   // Decode the upcoming state into strobe levels; write and read never overlap.
   always_comb begin
      ce_n_s = 1'b1;
      we_n_s = 1'b1;
      oe_n_s = 1'b1;
      doe_s  = 1'b0;
      case (state_nxt)
         WR_SETUP: begin
            ce_n_s = 1'b0;
            doe_s  = 1'b1;
         end
         WR_STROBE: begin
            ce_n_s = 1'b0;
            we_n_s = 1'b0;
            doe_s  = 1'b1;
         end
         RD_SETUP, RD_SAMPLE: begin
            ce_n_s = 1'b0;
            oe_n_s = 1'b0;
         end
         default: begin
            ce_n_s = 1'b1;
            we_n_s = 1'b1;
            oe_n_s = 1'b1;
            doe_s  = 1'b0;
         end
      endcase
   end

   // Strobe output registers, idle (all high, bus released) under reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_ce_n <= 1'b1;
         ram_we_n <= 1'b1;
         ram_oe_n <= 1'b1;
         data_oe  <= 1'b0;
      end else begin
         ram_ce_n <= ce_n_s;
         ram_we_n <= we_n_s;
         ram_oe_n <= oe_n_s;
         data_oe  <= doe_s;
      end
   end

endmodule

// File: rtl/ram_fill_check.sv
// Fills all RAM words with seed+address, then reads them back and compares,
// reporting pass/fail, a mismatch count and the first failing address.
module ram_fill_check #(
   parameter int ADDR_W = ram_pkg::ADDR_W,
   parameter int DATA_W = ram_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] seed,
   output logic [ADDR_W-1:0] adrs,
   output logic [DATA_W-1:0] data_wr,
   output logic              data_oe,
   output logic              ram_ce_n,
   output logic              ram_we_n,
   output logic              ram_oe_n,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic              first_err_vld,
   output logic [ADDR_W-1:0] first_err_adrs
);

   import ram_pkg::*;

   fc_state_t         state_r;
   fc_state_t         state_nxt_s;
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W-1:0] idx_nxt_s;
   logic [DATA_W-1:0] seed_q_r;
   logic [DATA_W-1:0] seed_nxt_s;
   logic [7:0]        err_nxt_s;
   logic              fev_nxt_s;
   logic [ADDR_W-1:0] fea_nxt_s;
   logic              in_run_s;
   logic              nxt_run_s;
   logic              last_s;
   logic              mismatch_s;

   assign in_run_s   = !(state_r inside {IDLE, DONE});
   assign nxt_run_s  = !(state_nxt_s inside {IDLE, DONE});
   assign last_s     = (idx_r == {ADDR_W{1'b1}});
   assign mismatch_s = (ram_dout != pat(seed_q_r, idx_r));

   // Next-state, index and result bookkeeping; abort beats start and the compare.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      seed_nxt_s  = seed_q_r;
      err_nxt_s   = err_count;
      fev_nxt_s   = first_err_vld;
      fea_nxt_s   = first_err_adrs;
      if (abort && in_run_s) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start && !abort) begin
                  state_nxt_s = WR_SETUP;
                  seed_nxt_s  = seed;
                  idx_nxt_s   = {ADDR_W{1'b0}};
                  err_nxt_s   = 8'd0;
                  fev_nxt_s   = 1'b0;
                  fea_nxt_s   = {ADDR_W{1'b0}};
               end else begin
                  state_nxt_s = state_r;
               end
            end
            WR_SETUP:  state_nxt_s = WR_STROBE;
            WR_STROBE: begin
               if (last_s) begin
                  idx_nxt_s   = {ADDR_W{1'b0}};
                  state_nxt_s = GAP;
               end else begin
                  idx_nxt_s   = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  state_nxt_s = WR_SETUP;
               end
            end
            GAP:       state_nxt_s = RD_SETUP;
            RD_SETUP:  state_nxt_s = RD_SAMPLE;
            RD_SAMPLE: begin
               if (mismatch_s) begin
                  err_nxt_s = err_count + 8'd1;
                  if (!first_err_vld) begin
                     fev_nxt_s = 1'b1;
                     fea_nxt_s = idx_r;
                  end else begin
                     fev_nxt_s = first_err_vld;
                  end
               end else begin
                  err_nxt_s = err_count;
               end
               if (last_s) begin
                  state_nxt_s = DONE;
               end else begin
                  idx_nxt_s   = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  state_nxt_s = RD_SETUP;
               end
            end
            default:   state_nxt_s = IDLE;
         endcase
      end
   end

   // State, datapath and status registers; address/data register the next index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         idx_r          <= {ADDR_W{1'b0}};
         seed_q_r       <= {DATA_W{1'b0}};
         adrs           <= {ADDR_W{1'b0}};
         data_wr        <= {DATA_W{1'b0}};
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 8'd0;
         first_err_vld  <= 1'b0;
         first_err_adrs <= {ADDR_W{1'b0}};
      end else begin
         state_r        <= state_nxt_s;
         idx_r          <= idx_nxt_s;
         seed_q_r       <= seed_nxt_s;
         adrs           <= idx_nxt_s;
         data_wr        <= pat(seed_nxt_s, idx_nxt_s);
         busy           <= nxt_run_s;
         done           <= (state_nxt_s == DONE);
         pass           <= (state_nxt_s == DONE) && (err_nxt_s == 8'd0);
         err_count      <= err_nxt_s;
         first_err_vld  <= fev_nxt_s;
         first_err_adrs <= fea_nxt_s;
      end
   end

   ram_strobe_gen u_strobe (
      .clk       (clk),
      .rst       (rst),
      .state_nxt (state_nxt_s),
      .ram_ce_n  (ram_ce_n),
      .ram_we_n  (ram_we_n),
      .ram_oe_n  (ram_oe_n),
      .data_oe   (data_oe)
   );

endmodule

// File: tb/tb_ram_fill_check.sv
// Bench for ram_fill_check: behavioural RAM with optional stuck bit, a
// cycle-count model of the run checked every cycle, plus literal pins.
module tb_ram_fill_check;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [15:0] seed;
   logic [6:0]  adrs;
   logic [15:0] data_wr, ram_dout;
   logic        data_oe, ram_ce_n, ram_we_n, ram_oe_n;
   logic        busy, done, pass, first_err_vld;
   logic [7:0]  err_count;
   logic [6:0]  first_err_adrs;

   logic [15:0] mem [0:127];
   logic        stuck_en;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_fill_check dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
      .adrs(adrs), .data_wr(data_wr), .data_oe(data_oe),
      .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
      .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_vld(first_err_vld),
      .first_err_adrs(first_err_adrs)
   );

   // RAM: write on a clock edge with ce/we low; read is combinational.
   always @(posedge clk)
      if (!ram_ce_n && !ram_we_n && data_oe)
         mem[adrs] <= (stuck_en && adrs == 7'h25) ? (data_wr & 16'hFFF7) : data_wr;
   assign ram_dout = mem[adrs];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_pat(input logic [15:0] s, input int w);
      return 16'(s + w);
   endfunction

   // Model: m_mode 0=idle, 1=running (m_k = cycle number since start), 2=done.
   int          m_mode = 0, m_k = 0;
   logic        m_valid = 1'b0, m_rstv = 1'b0;
   logic [15:0] m_seed;
   int          m_err;
   logic        m_fev;
   logic [6:0]  m_fea;

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b1; m_rstv <= 1'b1; m_mode <= 0; m_k <= 0;
         m_seed <= 16'd0; m_err <= 0; m_fev <= 1'b0; m_fea <= 7'd0;
      end else if (m_mode == 1) begin
         if (abort) begin
            m_mode <= 0; m_rstv <= 1'b0;
         end else begin
            if (m_k >= 259 && ((m_k - 259) % 2) == 0 &&
                mem[(m_k - 259) / 2] != exp_pat(m_seed, (m_k - 259) / 2)) begin
               m_err <= m_err + 1;
               if (!m_fev) begin
                  m_fev <= 1'b1; m_fea <= 7'((m_k - 259) / 2);
               end
            end
            if (m_k == 513) m_mode <= 2;
            else m_k <= m_k + 1;
         end
      end else if (start && !abort) begin
         m_mode <= 1; m_k <= 1; m_seed <= seed; m_err <= 0;
         m_fev <= 1'b0; m_fea <= 7'd0; m_rstv <= 1'b0;
      end
   end

   // Per-cycle compare of every output against the model, plus bus safety rules.
   logic [6:0] prev_adrs = 7'd0;
   always @(negedge clk) begin
      automatic logic       e_ce = 1'b1, e_we = 1'b1, e_oe = 1'b1, e_doe = 1'b0;
      automatic logic [6:0] e_adrs = 7'd0;
      automatic logic [15:0] e_data = 16'd0;
      automatic logic       c_adrs = m_rstv, c_data = m_rstv;
      automatic int         w;
      if (m_valid) begin
         if (m_mode == 1 && m_k <= 256) begin
            w = (m_k - 1) / 2;
            e_adrs = 7'(w); e_data = exp_pat(m_seed, w);
            e_ce = 1'b0; e_doe = 1'b1; e_we = (m_k % 2 == 1);
            c_adrs = 1'b1; c_data = 1'b1;
         end else if (m_mode == 1 && m_k >= 258) begin
            w = (m_k - 258) / 2;
            e_adrs = 7'(w); e_ce = 1'b0; e_oe = 1'b0;
            c_adrs = 1'b1; c_data = 1'b0;
         end
         chk("busy", busy, m_mode == 1);
         chk("done", done, m_mode == 2);
         chk("pass", pass, m_mode == 2 && m_err == 0);
         chk("ram_ce_n", ram_ce_n, e_ce);
         chk("ram_we_n", ram_we_n, e_we);
         chk("ram_oe_n", ram_oe_n, e_oe);
         chk("data_oe", data_oe, e_doe);
         chk("err_count", err_count, m_err);
         chk("first_err_vld", first_err_vld, m_fev);
         chk("first_err_adrs", first_err_adrs, m_fea);
         if (c_adrs) chk("adrs", adrs, e_adrs);
         if (c_data) chk("data_wr", data_wr, e_data);
         chk("we_oe_exclusive", (!ram_we_n && !ram_oe_n), 1'b0);
         if (!ram_we_n) chk("adrs_stable_we", adrs, prev_adrs);
      end
      prev_adrs <= adrs;
   end

   task automatic run_start(input logic [15:0] s);
      @(negedge clk);
      seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for done; optional spurious start pulse at iteration spur.
   task automatic wait_done(input int spur, output int n);
      n = 0;
      while (!done && n < 600) begin
         start = (n == spur);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("done_seen", done, 1'b1);
   endtask

   int n;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; seed = 16'd0; stuck_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", busy, 1'b0);
      chk("reset_ce_n", ram_ce_n, 1'b1);
      chk("reset_adrs", adrs, 7'd0);
      chk("reset_data_wr", data_wr, 16'd0);

      // Basic run with seed 0x264C; done exactly at T+514.
      run_start(16'h264C);
      wait_done(-1, n);
      chk("done_latency", n, 513);
      chk("mem0_264c", mem[0], 16'h264C);
      chk("mem127_264c", mem[127], 16'h26CB);
      chk("pass_264c", pass, 1'b1);
      chk("err_264c", err_count, 8'd0);

      // Wrap-around pattern, started from DONE.
      run_start(16'hFFF0);
      wait_done(-1, n);
      chk("mem0f_fff0", mem[15], 16'hFFFF);
      chk("mem10_fff0", mem[16], 16'h0000);
      chk("mem7f_fff0", mem[127], 16'h006F);
      chk("pass_fff0", pass, 1'b1);

      // Stuck bit 3 at address 0x25.
      stuck_en = 1'b1;
      run_start(16'h0008);
      wait_done(-1, n);
      chk("err_stuck", err_count, 8'd1);
      chk("fev_stuck", first_err_vld, 1'b1);
      chk("fea_stuck", first_err_adrs, 7'h25);
      chk("pass_stuck", pass, 1'b0);
      stuck_en = 1'b0;

      // Abort sampled at edge T+100.
      run_start(16'h1234);
      repeat (99) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_done", done, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_we_n", ram_we_n, 1'b1);
      chk("abort_ce_n", ram_ce_n, 1'b1);
      chk("abort_doe", data_oe, 1'b0);
      run_start(16'h4321);
      wait_done(-1, n);
      chk("pass_after_abort", pass, 1'b1);

      // Ignored start at T+50, reset at T+300.
      run_start(16'hA5A5);
      repeat (49) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (249) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_oe_n", ram_oe_n, 1'b1);
      chk("rst_adrs", adrs, 7'd0);
      chk("rst_err", err_count, 8'd0);

      // Randomised runs with spurious start pulses mid-run.
      for (int r = 0; r < 3; r++) begin
         stuck_en = 1'($urandom_range(0, 1));
         run_start(16'($urandom));
         wait_done(int'($urandom_range(1, 400)), n);
         chk("rand_latency", n, 513);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_fill_check.md
# ram_fill_check

Sequencer that sits directly upstream of `ram128x16` and replaces a hand-driven bench loop with a clocked controller. On `start` it writes the pattern `seed + address` into all 128 words, releases the RAM for one cycle, then reads every word back and compares it against the same pattern. It reports pass or fail, an error count and the first failing address. It is the standard self-check stage for the RAM in system bring-up.

## Interface
Parameters:
- `ADDR_W`, 7, address width; depth is 2^ADDR_W = 128.
- `DATA_W`, 16, word width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only in IDLE or DONE.
- `abort`  in  1  stops the current run and returns the block to IDLE.
- `seed`  in  DATA_W  pattern base; captured when `start` is accepted.
- `adrs`  out  ADDR_W  RAM address.
- `data_wr`  out  DATA_W  RAM write data.
- `data_oe`  out  1  tristate enable for `data_wr` onto the RAM `dataIn` bus.
- `ram_ce_n`, `ram_we_n`, `ram_oe_n`  out  1 each  active-low RAM strobes.
- `ram_dout`  in  DATA_W  RAM `dataOut`; the RAM read path is combinational.
- `busy`  out  1  high from the cycle after `start` acceptance until DONE or IDLE.
- `done`  out  1  held high in DONE.
- `pass`  out  1  `done && err_count == 0`.
- `err_count`  out  8  number of mismatching words.
- `first_err_vld`  out  1  set at the first mismatch.
- `first_err_adrs`  out  ADDR_W  address of the first mismatch.

## Operation
- States: IDLE, WR_SETUP, WR_STROBE, GAP, RD_SETUP, RD_SAMPLE, DONE.
- IDLE or DONE + `start`:
  - capture `seed`;
  - clear `idx`, `err_count` and `first_err_*`;
  - go to WR_SETUP.
- WR_SETUP:
  - `adrs = idx`, `data_wr = seed_q + idx` (mod 2^DATA_W), `data_oe = 1`;
  - `ram_ce_n = 0`, `ram_we_n = 1`, `ram_oe_n = 1`;
  - go to WR_STROBE.
- WR_STROBE:
  - same address and data, `ram_we_n = 0`;
  - if `idx == 127`: clear `idx`, go to GAP;
  - else: `idx++`, go to WR_SETUP.
- GAP: all strobes high, `data_oe = 0`; go to RD_SETUP.
- RD_SETUP: `adrs = idx`, `ram_ce_n = 0`, `ram_oe_n = 0`, `ram_we_n = 1`; go to RD_SAMPLE.
- RD_SAMPLE:
  - strobes and address held as in RD_SETUP;
  - compare `ram_dout` against `seed_q + idx`;
  - on mismatch: `err_count++`; if `!first_err_vld`, load `first_err_adrs = idx` and set `first_err_vld`;
  - if `idx == 127`: go to DONE;
  - else: `idx++`, go to RD_SETUP.
- DONE: strobes high, `done = 1`, results held until the next accepted `start` or `rst`.
- Pattern arithmetic: `seed_q` plus the zero-extended `idx`, truncated to DATA_W. Example: seed 0xFFF0 at address 0x7F gives 0x006F.
- `err_count` has a maximum of 128, which fits in 8 bits; no saturation logic.
- `start` while busy is ignored.
- `abort`:
  - in any busy state, next state is IDLE;
  - strobes deasserted and `data_oe = 0` from the next cycle;
  - `done` stays 0; `err_count` and `first_err_*` keep their partial values;
  - `abort` has priority over `start` in the same cycle.
- `rst`, including mid-run:
  - state IDLE, `idx = 0`;
  - `adrs = 0`, `data_wr = 0`, `data_oe = 0`;
  - `ram_ce_n`, `ram_we_n`, `ram_oe_n` = 1;
  - `busy`, `done`, `pass`, `err_count`, `first_err_vld`, `first_err_adrs` = 0.
- `rst` has priority over `abort` and `start`.

## Timing
- `start` sampled high at edge T (state IDLE or DONE): WR_SETUP for address 0 begins at T+1.
- Write phase: 2 cycles per word, 256 cycles total, T+1 to T+256.
- GAP: T+257.
- Read phase: 2 cycles per word, 256 cycles total, T+258 to T+513.
- `done` and `pass` are valid from T+514; `busy` falls at the same edge.
- `data_wr` and `adrs` are stable across both cycles of each word, so there is no address change while `ram_we_n = 0`.
- `ram_we_n` and `ram_oe_n` are never low together; the GAP cycle guarantees bus turnaround.
- All outputs are registered, with no combinational path from `ram_dout` to any output. Compare results update at the edge ending RD_SAMPLE.

## Structure
- Shared package `ram_pkg`:
  - `ADDR_W`, `DATA_W`, `DEPTH`;
  - state enum `fc_state_t`;
  - pattern function `pat(seed, adrs)`.
- One sub-module, `ram_strobe_gen`: a registered decode of state to `ram_ce_n`, `ram_we_n`, `ram_oe_n` and `data_oe`, kept separate so the mutual-exclusion assertion lives in one place.
- Top level: FSM, `idx` counter, `seed_q` register, comparator, error registers.

## Test plan
- Reset, then `start` with seed 0x264C (9804):
  - bench RAM holds 0x264C+i at every address i after the write phase;
  - `done` at T+514, `pass` = 1, `err_count` = 0.
- Seed 0xFFF0:
  - address 0x0F holds 0xFFFF, address 0x10 holds 0x0000, address 0x7F holds 0x006F;
  - `pass` = 1.
- Bench RAM model with bit 3 of address 0x25 stuck at 0, seed 0x0008:
  - `err_count` = 1, `first_err_vld` = 1, `first_err_adrs` = 0x25, `pass` = 0.
- `abort` at cycle T+100:
  - IDLE from T+101 with all strobes high;
  - `done` = 0; subsequent `start` gives a full run with `pass` = 1.
- `rst` at T+300 (read phase) and `start` pulsed at T+50: all outputs at reset values after the `rst` edge; the `start` at T+50 is ignored (no run restart).
- Assertion across all runs: never `!ram_we_n && !ram_oe_n`; `adrs` is constant whenever `ram_we_n = 0`.
